cac_seq_decoder: RTL and testbench

//  Sequential, runtime-configurable Fibonacci-numeral-system (FNS) CAC decoder controller.
//  - Accepts one CW-bit CAC codeword per valid/ready transaction.
//  - Holds a writable weight table, one weight per code bit.
//  - Sums the weights of the set bits, one bit per cycle, in a single shared adder.
//  - Sits on the receive side of a CAC link, where the local FNS weights are reconfigured at runtime.

---
 rtl/cac_seq_decoder_if.sv | 30 +++
 rtl/cac_seq_decoder.sv | 109 ++++++++++
 tb/tb_cac_seq_decoder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cac_seq_decoder_if.sv
// Handshake and weight-configuration bundle for the FNS CAC decoder.
// The slave modport is the decoder side; the master modport is the link/consumer side.
interface cac_seq_decoder_if #(
    parameter int CW = 7,
    parameter int WW = 6,
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_code;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_ovf;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [WW-1:0] cfg_wdata;
    logic          cfg_err;

    modport slave (
        input  in_valid, in_code, out_ready, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_data, out_ovf, cfg_err
    );

    modport master (
        output in_valid, in_code, out_ready, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_data, out_ovf, cfg_err
    );
endinterface

// File: rtl/cac_seq_decoder.sv
// Sequential FNS CAC decoder: sums runtime-configurable weights of the set code bits,
// one bit per cycle through a single shared adder, MSB first.
module cac_seq_decoder #(
    parameter int CW = 7,
    parameter int WW = 6,
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    cac_seq_decoder_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AW:0] CW_A = (AW+1)'(CW);

    state_t        state, state_nxt;
    logic [CW-1:0] code;
    logic [DW-1:0] acc;
    logic          ovf;
    logic          drain;
    logic [AW-1:0] idx;
    logic [WW-1:0] w [CW];
    logic [DW:0]   sum;
    logic          accept;
    logic          cfg_ok;

    function automatic logic [WW-1:0] fib_weight(input int n);
        int a;
        int b;
        int t;
        a = 1;
        b = 1;
        for (int k = 2; k <= n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return WW'(b);
    endfunction

    assign accept = bus.in_valid && (state == IDLE);
    assign sum    = {1'b0, acc} + (DW+1)'(w[idx]);
    // Entries 0 and 1 are fixed at 1, and the table is frozen while a codeword is in flight.
    assign cfg_ok = (state == IDLE) && (bus.cfg_addr > AW'(1)) && ({1'b0, bus.cfg_addr} < CW_A);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (drain) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // After the last bit is summed, one more RUN cycle copies acc/ovf into the output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code         <= '0;
            acc          <= '0;
            ovf          <= 1'b0;
            drain        <= 1'b0;
            idx          <= '0;
            bus.out_data <= '0;
            bus.out_ovf  <= 1'b0;
            bus.cfg_err  <= 1'b0;
            for (int i = 0; i < CW; i++) w[i] <= fib_weight(i);
        end else begin
            bus.cfg_err <= bus.cfg_we && !cfg_ok;
            if (bus.cfg_we && cfg_ok) w[bus.cfg_addr] <= bus.cfg_wdata;

            if (accept) begin
                code  <= bus.in_code;
                acc   <= '0;
                ovf   <= 1'b0;
                drain <= 1'b0;
                idx   <= AW'(CW - 1);
            end else if (state == RUN && !drain) begin
                if (code[idx]) begin
                    acc <= sum[DW-1:0];
                    if (sum[DW]) ovf <= 1'b1;
                end
                if (idx == '0) drain <= 1'b1;
                else           idx   <= idx - 1'b1;
            end else if (state == RUN && drain) begin
                bus.out_data <= acc;
                bus.out_ovf  <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_cac_seq_decoder.sv
// Directed bench for cac_seq_decoder: stimulus pushes expected results into a queue,
// an independent monitor pops and compares on every output handshake.
module tb_cac_seq_decoder;

    localparam int CW = 7;
    localparam int WW = 6;
    localparam int DW = 8;
    localparam int AW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    exp_t sb[$];

    cac_seq_decoder_if #(.CW(CW), .WW(WW), .DW(DW), .AW(AW)) bus ();

    cac_seq_decoder #(.CW(CW), .WW(WW), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: a result leaves the DUT at the posedge following a negedge with valid and ready high.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got data %0d expected no output", bus.out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("out_data", 32'(bus.out_data), 32'(e.data));
                checkOutput("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic driveCode(input logic [CW-1:0] code);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got %b expected 1", bus.in_ready);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [CW-1:0] code, input logic [DW-1:0] data, input logic ovf);
        exp_t e;
        e.data = data;
        e.ovf  = ovf;
        sb.push_back(e);
        driveCode(code);
    endtask

    task automatic cfgWrite(input logic [AW-1:0] addr, input logic [WW-1:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.in_ready !== 1'b1) && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0 || bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        int lat;
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.out_ready = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        tick();
        tick();

        // Reset state
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        checkOutput("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Default weights 1,1,2,3,5,8,13
        applyStimulus(7'b1111111, 8'd33, 1'b0);
        waitValid(lat);
        checkOutput("latency_all_ones", 32'(lat), 32'd8);
        waitIdle();

        applyStimulus(7'b1010101, 8'd21, 1'b0);
        waitIdle();
        applyStimulus(7'b0000000, 8'd0, 1'b0);
        waitValid(lat);
        checkOutput("latency_all_zero", 32'(lat), 32'd8);
        waitIdle();

        // Weight writes and protected entries
        cfgWrite(3'd6, 6'd40);
        checkOutput("cfg_err_valid_write", 32'(bus.cfg_err), 32'd0);
        applyStimulus(7'b1000000, 8'd40, 1'b0);
        waitIdle();
        cfgWrite(3'd1, 6'd9);
        checkOutput("cfg_err_addr1", 32'(bus.cfg_err), 32'd1);
        tick();
        checkOutput("cfg_err_one_cycle", 32'(bus.cfg_err), 32'd0);
        applyStimulus(7'b0000010, 8'd1, 1'b0);
        waitIdle();
        cfgWrite(3'd7, 6'd9);
        checkOutput("cfg_err_addr7", 32'(bus.cfg_err), 32'd1);

        // Overflow: 63*5 + 1 + 1 = 317 -> 61 with ovf
        for (int a = 2; a < CW; a++) cfgWrite(AW'(a), 6'd63);
        applyStimulus(7'b1111111, 8'd61, 1'b1);
        waitIdle();
        applyStimulus(7'b0000001, 8'd1, 1'b0);
        waitIdle();

        // Backpressure in DONE
        bus.out_ready = 1'b0;
        applyStimulus(7'b0000011, 8'd2, 1'b0);
        waitValid(lat);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stall_out_data", 32'(bus.out_data), 32'd2);
            checkOutput("stall_out_ovf", 32'(bus.out_ovf), 32'd0);
            checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        waitIdle();

        // Write attempt while RUN must be dropped
        applyStimulus(7'b0000100, 8'd63, 1'b0);
        cfgWrite(3'd2, 6'd5);
        checkOutput("cfg_err_in_run", 32'(bus.cfg_err), 32'd1);
        waitIdle();

        // Reset during the third RUN cycle discards the codeword and restores weights
        driveCode(7'b1111111);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 12; k++) tick();
        applyStimulus(7'b1111111, 8'd33, 1'b0);
        waitIdle();
        applyStimulus(7'b1000000, 8'd13, 1'b0);
        waitIdle();

        for (int k = 0; k < 5; k++) tick();
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
